seg_display_scheduler: RTL and testbench

Time-shares the board's single 8-digit common-anode 7-segment display between up to NUM_REQ result producers.
- Round-robin arbiter grants the display to one requester and latches its 13-bit value.
- Sub-unit converts the value to 4 BCD digits sequentially (double-dabble).
- Scan engine multiplexes the anodes continuously: requester index on the leftmost digit, value on the right four digits.

---
 rtl/seg_pkg.sv | 59 +++++
 rtl/seg_display_scheduler_bin2bcd_seq.sv | 76 +++++++
 rtl/seg_display_scheduler.sv | 234 +++++++++++++++++++++++
 tb/tb_seg_display_scheduler.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and helpers for the 7-segment display scheduler:
// active-low segment codes, FSM state encoding and the slot-to-anode mapping.
package seg_pkg;

    // Segment codes, {G,F,E,D,C,B,A}, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Any non-decimal digit code renders blank; this one is used on purpose
    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    // Anode mapping: slot 7 is the leftmost digit and carries the owner index
    localparam logic [2:0] SLOT_OWNER = 3'd7;
    localparam logic [7:0] AN_ALL_OFF = 8'hFF;

    // BCD result width: four digits
    localparam int BCD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_SHOW    = 2'd2
    } state_t;

    function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] slot_to_an(input logic [2:0] slot);
        logic [7:0] an;
        an       = AN_ALL_OFF;
        an[slot] = 1'b0;
        return an;
    endfunction

endpackage

// File: rtl/seg_display_scheduler_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift/add-3 step per clock,
// DATA_W steps per conversion. busy is high for exactly DATA_W cycles after
// start; done pulses for one cycle once the four BCD digits are final.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int DATA_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] value,
    output logic              busy,
    output logic              done,
    output logic [BCD_W-1:0]  bcd
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic [BCD_W-1:0]  bcd_reg;
    logic [BCD_W-1:0]  bcd_adj;
    logic [BCD_W-1:0]  bcd_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic              busy_reg;
    logic              done_reg;

    // Add-3 correction on every BCD digit that is 5 or more before the shift
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5)
                                      ? bcd_reg[gi*4 +: 4] + 4'd3
                                      : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    // Shift the {bcd, binary} pair left by one, feeding the binary MSB in
    always_comb begin
        bcd_next   = {bcd_adj[BCD_W-2:0], shift_reg[DATA_W-1]};
        shift_next = {shift_reg[DATA_W-2:0], 1'b0};
    end

    // Iteration state: load on start, then step until DATA_W shifts are done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            bcd_reg   <= '0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                shift_reg <= value;
                bcd_reg   <= '0;
                cnt_reg   <= '0;
                busy_reg  <= 1'b1;
            end else if (busy_reg) begin
                shift_reg <= shift_next;
                bcd_reg   <= bcd_next;
                cnt_reg   <= cnt_reg + 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign bcd  = bcd_reg;

endmodule

// File: rtl/seg_display_scheduler.sv
// Time-shares one 8-digit common-anode 7-segment display between NUM_REQ
// producers: round-robin grant, sequential BCD conversion, continuous scan.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks leading zeros of the
// value (ones digit always shown).
module seg_display_scheduler
    import seg_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 13,
    parameter int REFRESH_DIV  = 100000,
    parameter int DWELL_FRAMES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] data,
    output logic [NUM_REQ-1:0]        ack,
    output logic [3:0]                owner,
    output logic                      busy,
    output logic [7:0]                AN,
    output logic [6:0]                seg
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FC_W  = $clog2(DWELL_FRAMES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(REFRESH_DIV - 1);
    localparam logic [FC_W-1:0]  DWELL_LAST = FC_W'(DWELL_FRAMES);

    state_t               state_reg, state_next;
    logic [3:0]           ptr_reg;
    logic [3:0]           owner_reg;
    logic [NUM_REQ-1:0]   ack_reg;
    logic [NUM_REQ-1:0]   ack_next;
    logic [FC_W-1:0]      frame_cnt_reg;
    logic [DIV_W-1:0]     div_reg;
    logic [2:0]           slot_reg;
    logic [7:0]           an_reg;
    logic [6:0]           seg_reg;
    logic [3:0]           disp_owner_reg;
    logic [3:0][3:0]      disp_dig_reg;
    logic                 disp_valid_reg;

    logic [DATA_W-1:0]    data_arr [NUM_REQ];
    logic                 win_found;
    logic [3:0]           win_idx;
    logic [DATA_W-1:0]    win_data;
    logic                 grant;
    logic                 load_disp;
    logic                 div_tc;
    logic                 frame_wrap;
    logic                 conv_busy;
    logic                 conv_done;
    logic [BCD_W-1:0]     conv_bcd;
    logic [3:0][3:0]      dig_load;
    logic [3:0]           slot_digit;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_data
            assign data_arr[gi] = data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Round-robin search starting one past the last winner
    always_comb begin
        int cand;
        win_found = 1'b0;
        win_idx   = ptr_reg;
        cand      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(ptr_reg) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = 4'(cand);
            end
        end
    end

    // Winner's value and one-hot acknowledge
    always_comb begin
        win_data = '0;
        ack_next = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (4'(k) == win_idx) begin
                win_data    = data_arr[k];
                ack_next[k] = grant;
            end
        end
    end

    // FSM next state: grant from IDLE at once, from SHOW only after the dwell
    always_comb begin
        state_next = state_reg;
        grant      = 1'b0;
        load_disp  = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (win_found) begin
                    grant      = 1'b1;
                    state_next = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (conv_done) begin
                    load_disp  = 1'b1;
                    state_next = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (frame_cnt_reg == DWELL_LAST && win_found) begin
                    grant      = 1'b1;
                    state_next = ST_CONVERT;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    // Grant bookkeeping: pointer, owner and the one-cycle ack pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg   <= 4'(NUM_REQ - 1);
            owner_reg <= 4'd0;
            ack_reg   <= '0;
        end else begin
            ack_reg <= ack_next;
            if (grant) begin
                ptr_reg   <= win_idx;
                owner_reg <= win_idx;
            end
        end
    end

    bin2bcd_seq #(
        .DATA_W (DATA_W)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (grant),
        .value (win_data),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Digits as they will be stored, with optional leading-zero suppression
    always_comb begin
        dig_load = conv_bcd;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (conv_bcd[15:12] == 4'd0) begin
            dig_load[3] = DIGIT_BLANK;
            if (conv_bcd[11:8] == 4'd0) begin
                dig_load[2] = DIGIT_BLANK;
                if (conv_bcd[7:4] == 4'd0) dig_load[1] = DIGIT_BLANK;
            end
        end
`endif
    end

    // Display buffer: only replaced when a conversion completes, so the old
    // value stays on screen while the next one converts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_owner_reg <= DIGIT_BLANK;
            disp_dig_reg   <= {4{DIGIT_BLANK}};
            disp_valid_reg <= 1'b0;
        end else if (load_disp) begin
            disp_owner_reg <= owner_reg;
            disp_dig_reg   <= dig_load;
            disp_valid_reg <= 1'b1;
        end
    end

    // Dwell counter: counts completed scan frames since the last load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_reg <= '0;
        end else if (load_disp) begin
            frame_cnt_reg <= '0;
        end else if (frame_wrap && frame_cnt_reg != DWELL_LAST) begin
            frame_cnt_reg <= frame_cnt_reg + 1'b1;
        end
    end

    assign div_tc     = (div_reg == DIV_LAST);
    assign frame_wrap = div_tc && (slot_reg == 3'd0);

    // Scan timebase: divider and slot counter, slot walks 7 down to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg  <= '0;
            slot_reg <= SLOT_OWNER;
        end else if (div_tc) begin
            div_reg  <= '0;
            slot_reg <= slot_reg - 3'd1;
        end else begin
            div_reg <= div_reg + 1'b1;
        end
    end

    // Digit code for the current slot (slots 6..4 are always blank)
    always_comb begin
        slot_digit = DIGIT_BLANK;
        if (slot_reg == SLOT_OWNER)  slot_digit = disp_owner_reg;
        else if (slot_reg <= 3'd3)   slot_digit = disp_dig_reg[slot_reg[1:0]];
    end

    // Registered anode/cathode drive; anodes stay off until a value exists
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_reg  <= AN_ALL_OFF;
            seg_reg <= SEG_BLANK;
        end else if (!disp_valid_reg) begin
            an_reg  <= AN_ALL_OFF;
            seg_reg <= SEG_BLANK;
        end else begin
            an_reg  <= slot_to_an(slot_reg);
            seg_reg <= digit_to_seg(slot_digit);
        end
    end

    assign ack   = ack_reg;
    assign owner = owner_reg;
    assign busy  = conv_busy;
    assign AN    = an_reg;
    assign seg   = seg_reg;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed testbench for seg_display_scheduler (REFRESH_DIV=4, DWELL_FRAMES=2).
module tb_seg_display_scheduler;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [51:0] data = '0;
    logic [3:0]  ack;
    logic [3:0]  owner;
    logic        busy;
    logic [7:0]  AN;
    logic [6:0]  seg;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    seg_display_scheduler #(
        .NUM_REQ      (4),
        .DATA_W       (13),
        .REFRESH_DIV  (4),
        .DWELL_FRAMES (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .data  (data),
        .ack   (ack),
        .owner (owner),
        .busy  (busy),
        .AN    (AN),
        .seg   (seg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for an ack pulse; returns the ack vector and cycle seen
    task automatic wait_ack(input string tag, output logic [3:0] a, output int at);
        bit seen;
        seen = 1'b0;
        a    = 4'b0;
        at   = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (ack !== 4'b0) begin
                seen = 1'b1;
                a    = ack;
                at   = cyc;
            end
        end
        check({tag, "_ack_seen"}, 32'(seen), 32'd1);
        $display("t=%0t %s grant ack=%b owner=%0d", $time, tag, a, owner);
    endtask

    // Wait (bounded) for the given slot to be driven, then check its segments
    task automatic check_slot(input string tag, input int s, input logic [6:0] exp);
        logic [7:0] pat;
        bit found;
        pat    = 8'hFF;
        pat[s] = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (AN === pat) found = 1'b1;
        end
        check($sformatf("%s_slot%0d_an", tag, s), 32'(found), 32'd1);
        check($sformatf("%s_slot%0d_seg", tag, s), 32'(seg), 32'(exp));
    endtask

    task automatic check_display(input string tag, input logic [6:0] e7,
                                 input logic [6:0] e3, input logic [6:0] e2,
                                 input logic [6:0] e1, input logic [6:0] e0);
        check_slot(tag, 7, e7);
        check_slot(tag, 6, SB);
        check_slot(tag, 5, SB);
        check_slot(tag, 4, SB);
        check_slot(tag, 3, e3);
        check_slot(tag, 2, e2);
        check_slot(tag, 1, e1);
        check_slot(tag, 0, e0);
        $display("t=%0t %s display checked", $time, tag);
    endtask

    initial begin
        logic [3:0] a;
        int t, t_prev, n;
        logic [3:0] exp_seq [5];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // 1: reset, then idle with no requests
        repeat (3) @(negedge clk);
        check("t1_in_reset", {AN, seg, ack, busy, owner}, {8'hFF, 7'h7F, 4'h0, 1'b0, 4'h0});
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("t1_idle", {AN, seg, ack, busy, owner}, {8'hFF, 7'h7F, 4'h0, 1'b0, 4'h0});
        end

        // 2: single request, value 1234
        data[0 +: 13] = 13'd1234;
        req = 4'b0001;
        wait_ack("t2", a, t);
        check("t2_ack", a, 4'b0001);
        check("t2_owner", owner, 0);
        req = 4'b0000;
        n = 0;
        while (busy === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
            if (n == 1) check("t2_ack_pulse", ack, 0);
        end
        check("t2_busy_cycles", n, 13);
        repeat (3) @(negedge clk);
        check_display("t2", S0, S1, S2, S3, S4);

        // 4a: maximum value 8191
        data[0 +: 13] = 13'd8191;
        req = 4'b0001;
        wait_ack("t4a", a, t);
        check("t4a_ack", a, 4'b0001);
        req = 4'b0000;
        repeat (20) @(negedge clk);
        check_display("t4a", S0, S8, S1, S9, S1);

        // 4b: value zero
        data[0 +: 13] = 13'd0;
        req = 4'b0001;
        wait_ack("t4b", a, t);
        check("t4b_ack", a, 4'b0001);
        req = 4'b0000;
        repeat (20) @(negedge clk);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        check_display("t4b", S0, SB, SB, SB, S0);
`else
        check_display("t4b", S0, S0, S0, S0, S0);
`endif

        // 6: no requests for 20 frames: no grants, display held, dwell saturated
        n = 0;
        for (int i = 0; i < 640; i++) begin
            @(negedge clk);
            if (ack !== 4'b0) n++;
        end
        check("t6_no_ack", n, 0);
        check("t6_frame_cnt_sat", 32'(dut.frame_cnt_reg), 2);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        check_display("t6", S0, SB, SB, SB, S0);
`else
        check_display("t6", S0, S0, S0, S0, S0);
`endif

        // 5: reset in the middle of a conversion
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        data[26 +: 13] = 13'd42;
        req = 4'b0100;
        rst = 1'b0;
        wait_ack("t5a", a, t);
        check("t5a_ack", a, 4'b0100);
        repeat (5) @(negedge clk);
        check("t5_busy_before_rst", busy, 1);
        rst = 1'b1;
        #1;
        check("t5_rst_outputs", {AN, seg, ack, busy, owner}, {8'hFF, 7'h7F, 4'h0, 1'b0, 4'h0});
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_ack("t5b", a, t);
        check("t5b_ack", a, 4'b0100);
        check("t5b_owner", owner, 2);
        repeat (20) @(negedge clk);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        check_display("t5", S2, SB, SB, S4, S2);
`else
        check_display("t5", S2, S0, S0, S4, S2);
`endif

        // 3: all requesting: round-robin order and dwell spacing
        @(negedge clk);
        rst = 1'b1;
        data = {13'd4444, 13'd3333, 13'd222, 13'd11};
        req = 4'b1111;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        t_prev = 0;
        for (int g = 0; g < 5; g++) begin
            wait_ack($sformatf("t3_g%0d", g), a, t);
            check($sformatf("t3_ack%0d", g), a, exp_seq[g]);
            check($sformatf("t3_owner%0d", g), owner, (g == 4) ? 0 : g);
            if (g > 0) check($sformatf("t3_gap%0d", g), 32'(t - t_prev >= 48 && t - t_prev <= 79), 1);
            t_prev = t;
        end
        req = 4'b0000;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
